// File: rtl/mux_rr_nx1.sv
// N-input registered mux with valid/ready on every port.
// Winner is either an external select or a round-robin scan.
module mux_rr_nx1 #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int MODE = 0,
  parameter int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic [SELW-1:0]   sel,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SELW-1:0]   out_chan
);

  logic            load;
  logic            grant;
  logic [SELW-1:0] winner;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] ptr_nxt;

  function automatic int rot(
    input logic [SELW-1:0] p,
    input int              k
  );
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return s;
  endfunction

  assign load = !out_valid || out_ready;

  // Reverse scan so the channel closest to ptr is written last
  always_comb begin
    grant  = 1'b0;
    winner = '0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          grant  = 1'b1;
          winner = SELW'(i);
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (in_valid[rot(ptr, k)]) begin
          grant  = 1'b1;
          winner = SELW'(rot(ptr, k));
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = !rst && load && grant
                    && (winner == SELW'(i));
    end
  end

  assign ptr_nxt = (winner == SELW'(N - 1))
                   ? '0 : winner + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= grant;
      if (grant) begin
        out_data <= in_data[winner*W +: W];
        out_chan <= winner;
        if (MODE == 1) ptr <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Bench for mux_rr_nx1: four instances (N=4/3, both modes)
// checked every cycle against a behavioural model.
module tb_mux_rr_nx1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  localparam int NT [4] = '{4, 4, 3, 3};
  localparam int MT [4] = '{0, 1, 1, 0};

  logic [3:0][7:0] dat  [4];
  logic [3:0]      vld  [4];
  logic [1:0]      sl   [4];
  logic            ordy [4];

  logic [7:0] od0, od1;
  logic [3:0] od2, od3;
  logic [3:0] ir0, ir1;
  logic [2:0] ir2, ir3;
  logic       ov0, ov1, ov2, ov3;
  logic [1:0] oc0, oc1, oc2, oc3;

  logic [7:0] od [4];
  logic [3:0] ir [4];
  logic       ov [4];
  logic [1:0] oc [4];

  assign od[0] = od0;
  assign od[1] = od1;
  assign od[2] = {4'h0, od2};
  assign od[3] = {4'h0, od3};
  assign ir[0] = ir0;
  assign ir[1] = ir1;
  assign ir[2] = {1'b0, ir2};
  assign ir[3] = {1'b0, ir3};
  assign ov[0] = ov0;
  assign ov[1] = ov1;
  assign ov[2] = ov2;
  assign ov[3] = ov3;
  assign oc[0] = oc0;
  assign oc[1] = oc1;
  assign oc[2] = oc2;
  assign oc[3] = oc3;

  mux_rr_nx1 #(.N(4), .W(8), .MODE(0)) u0 (
    .clk(clk), .rst(rst),
    .in_data(dat[0]), .in_valid(vld[0]),
    .in_ready(ir0), .sel(sl[0]),
    .out_data(od0), .out_valid(ov0),
    .out_ready(ordy[0]), .out_chan(oc0)
  );

  mux_rr_nx1 #(.N(4), .W(8), .MODE(1)) u1 (
    .clk(clk), .rst(rst),
    .in_data(dat[1]), .in_valid(vld[1]),
    .in_ready(ir1), .sel(sl[1]),
    .out_data(od1), .out_valid(ov1),
    .out_ready(ordy[1]), .out_chan(oc1)
  );

  mux_rr_nx1 #(.N(3), .W(4), .MODE(1)) u2 (
    .clk(clk), .rst(rst),
    .in_data({dat[2][2][3:0], dat[2][1][3:0],
              dat[2][0][3:0]}),
    .in_valid(vld[2][2:0]),
    .in_ready(ir2), .sel(sl[2]),
    .out_data(od2), .out_valid(ov2),
    .out_ready(ordy[2]), .out_chan(oc2)
  );

  mux_rr_nx1 #(.N(3), .W(4), .MODE(0)) u3 (
    .clk(clk), .rst(rst),
    .in_data({dat[3][2][3:0], dat[3][1][3:0],
              dat[3][0][3:0]}),
    .in_valid(vld[3][2:0]),
    .in_ready(ir3), .sel(sl[3]),
    .out_data(od3), .out_valid(ov3),
    .out_ready(ordy[3]), .out_chan(oc3)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(
    input string       nm,
    input int          k,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h @%0t",
               nm, k, act, exp, $time);
    end
  endtask

  // Model state: output word, its channel, rr pointer
  bit         mv [4];
  logic [7:0] md [4];
  int         mc [4];
  int         mp [4];

  function automatic void mwin(
    input  int k,
    output bit g,
    output int wn
  );
    int c;
    g  = 1'b0;
    wn = 0;
    if (MT[k] == 0) begin
      if (int'(sl[k]) < NT[k] && vld[k][sl[k]]) begin
        g  = 1'b1;
        wn = int'(sl[k]);
      end
    end else begin
      for (int j = 0; j < NT[k]; j++) begin
        c = (mp[k] + j) % NT[k];
        if (!g && vld[k][c]) begin
          g  = 1'b1;
          wn = c;
        end
      end
    end
  endfunction

  bit ug;
  int uw;
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        mv[k] = 1'b0;
        md[k] = 8'h00;
        mc[k] = 0;
        mp[k] = 0;
      end else if (!mv[k] || ordy[k]) begin
        mwin(k, ug, uw);
        if (ug) begin
          if (k < 2) md[k] = dat[k][uw];
          else md[k] = {4'h0, dat[k][uw][3:0]};
          mc[k] = uw;
          mv[k] = 1'b1;
          if (MT[k] == 1) mp[k] = (uw + 1) % NT[k];
        end else begin
          mv[k] = 1'b0;
        end
      end
    end
  end

  bit         cg;
  int         cw;
  logic [3:0] er;
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      mwin(k, cg, cw);
      er = 4'h0;
      if (!rst && (!mv[k] || ordy[k]) && cg)
        er[cw] = 1'b1;
      chk("in_ready", k, ir[k], er);
      chk("out_valid", k, ov[k], mv[k]);
      chk("out_data", k, od[k], md[k]);
      chk("out_chan", k, oc[k], mc[k]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] t1 [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  int         s4 [5] = '{1, 3, 1, 3, 1};
  logic [3:0] t6 [4] = '{4'h5, 4'h6, 4'h7, 4'h5};

  initial begin
    for (int k = 0; k < 4; k++) begin
      vld[k]  = 4'h0;
      sl[k]   = 2'd0;
      ordy[k] = 1'b1;
    end
    dat[0] = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    dat[1] = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    dat[2] = {8'h00, 8'h07, 8'h06, 8'h05};
    dat[3] = {8'h00, 8'h07, 8'h06, 8'h05};
    rst = 1'b1;
    step();
    step();
    chk("rst_valid", 0, ov0, 0);
    chk("rst_data", 0, od0, 0);
    chk("rst_chan", 1, oc1, 0);
    rst = 1'b0;

    // external select walk
    vld[0] = 4'hF;
    for (int i = 0; i < 4; i++) begin
      sl[0] = 2'(i);
      step();
      chk("t1_data", i, od0, t1[i]);
      chk("t1_chan", i, oc0, i);
      chk("t1_valid", i, ov0, 1);
    end

    // backpressure hold then same-cycle refill
    sl[0] = 2'd2;
    step();
    chk("t2_first", 0, od0, 8'hC3);
    dat[0][2] = 8'h3C;
    ordy[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold", i, od0, 8'hC3);
      chk("t2_hvalid", i, ov0, 1);
      chk("t2_noready", i, ir0, 0);
    end
    ordy[0] = 1'b1;
    #1;
    chk("t2_ready", 0, ir0, 4'b0100);
    step();
    chk("t2_new", 0, od0, 8'h3C);
    vld[0] = 4'h0;
    step();
    chk("t2_drain", 0, ov0, 0);

    // round robin, all valid
    vld[1] = 4'hF;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t3_chan", i, oc1, i % 4);
    end

    // sparse valids, then idle with pointer hold
    vld[1] = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_chan", i, oc1, s4[i]);
    end
    vld[1] = 4'h0;
    step();
    chk("t4_idle", 0, ov1, 0);
    chk("t4_hold", 0, oc1, 1);
    step();
    vld[1] = 4'hF;
    step();
    chk("t4_ptr", 0, oc1, 2);

    // reset while a word is stalled
    ordy[1] = 1'b0;
    step();
    chk("t5_stall", 0, ov1, 1);
    rst = 1'b1;
    ordy[1] = 1'b1;
    #1;
    chk("t5_rready", 0, ir1, 0);
    step();
    chk("t5_valid", 0, ov1, 0);
    chk("t5_data", 0, od1, 0);
    chk("t5_chan", 0, oc1, 0);
    rst = 1'b0;
    step();
    chk("t5_first", 0, oc1, 0);
    chk("t5_fdata", 0, od1, 8'hA1);
    vld[1] = 4'h0;

    // N=3 wrap and out-of-range select
    vld[2] = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_chan", i, oc2, i % 3);
      chk("t6_data", i, od2, t6[i]);
    end
    vld[2] = 4'h0;
    vld[3] = 4'b0111;
    sl[3] = 2'd1;
    step();
    chk("t6_sel1", 0, od3, 4'h6);
    sl[3] = 2'd3;
    #1;
    chk("t6_oor_rdy", 0, ir3, 0);
    step();
    chk("t6_oor_val", 0, ov3, 0);
    chk("t6_oor_dat", 0, od3, 4'h6);

    // mixed traffic, model-checked
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 4; k++) begin
        vld[k]  = 4'($urandom);
        sl[k]   = 2'($urandom);
        ordy[k] = ($urandom_range(0, 3) != 0);
        dat[k]  = $urandom;
      end
      step();
    end

    step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_rr_nx1.md
Name: mux_rr_nx1

Overview:
- Parametrised N-input, W-bit registered multiplexer with a valid/ready handshake on every input and on the output.
- Selection mode is fixed by parameter: either external select, or fair round-robin arbitration among valid inputs.
- Generalises the combinational mux family to arbitrary width and channel count, adding registered output, backpressure and arbitration.
- Used wherever several producers share one downstream consumer.

Parameters:
- N, 4, number of input channels (N >= 2; need not be a power of 2).
- W, 8, data width per channel in bits.
- MODE, 0, selection mode: 0 = external select via sel, 1 = round-robin arbitration (sel ignored).
- SELW, $clog2(N), width of sel and out_chan (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N*W  packed channel data; channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational.
- sel  input  SELW  channel select (MODE 0 only).
- out_data  output  W  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- out_chan  output  SELW  index of the channel that supplied out_data (registered).

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - out_valid = 0, out_data = 0, out_chan = 0.
  - Round-robin pointer ptr = 0.
  - While rst = 1, in_ready = all 0.
- Load enable: load = !out_valid || out_ready. The output register accepts new data only when load = 1.
- Winner selection (combinational, evaluated each cycle):
  - MODE 0: a grant exists if sel < N and in_valid[sel] = 1; winner = sel. If sel >= N, there is no grant.
  - MODE 1: winner = the first i with in_valid[i] = 1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N). There is no grant if in_valid = 0.
- Handshake:
  - in_ready[i] = load && grant && (i == winner). At most one in_ready bit is high in any cycle.
  - A transfer on channel i occurs when in_valid[i] && in_ready[i].
  - Inputs must hold data and valid until accepted; the block never drops accepted data.
- Register update at each rising edge (rst = 0):
  - load && grant: out_data <= channel winner data, out_chan <= winner, out_valid <= 1.
  - load && !grant: out_valid <= 0; out_data and out_chan hold.
  - !load (out_valid = 1, out_ready = 0): all output registers hold; no input is accepted.
- Latency and throughput:
  - One cycle from input acceptance to out_valid.
  - Full throughput: one transfer per cycle when out_ready = 1 continuously.
- Pointer (MODE 1 only):
  - On grant, ptr <= winner + 1, wrapping N-1 -> 0 (explicit compare, not power-of-2 truncation).
  - With no grant, ptr holds.
  - In MODE 0, ptr stays 0.
- Simultaneous events: draining the output and accepting new data in the same cycle is a legal back-to-back transfer.
- Reset mid-operation:
  - rst overrides everything; any pending output word is discarded.
  - The first grant after release starts the scan from channel 0.
- Fairness (MODE 1): with all channels continuously valid and out_ready = 1, each channel is granted exactly once per N consecutive grants.

Test Plan:
1. MODE 0, N=4, W=8, in_data={D4,C3,B2,A1}, in_valid=4'b1111, out_ready=1, sel stepping 0,1,2,3 per cycle -> out_data A1,B2,C3,D4 with out_chan 0,1,2,3, each one cycle after its sel; out_valid stays 1.
2. Backpressure: MODE 0, sel=2, out_ready=0 for 3 cycles after the first transfer -> out_data=C3 and out_valid=1 held, in_ready=0 throughout. Then out_ready=1 -> in_ready[2]=1 and a new transfer occurs the same cycle.
3. MODE 1, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3.
4. MODE 1, in_valid=4'b1010 -> out_chan alternates 1,3,1,3. Then in_valid=0 -> out_valid falls next cycle and ptr holds.
5. Reset mid-operation: out_valid=1 with out_ready=0, assert rst for 1 cycle -> out_valid=0, out_data=0, out_chan=0, and in_ready=0 during rst. After release, in MODE 1 with all valid, the first out_chan is 0.
6. N=3, W=4 boundary checks:
   - MODE 1, all valid -> out_chan 0,1,2,0 (ptr wraps 2->0).
   - MODE 0, sel=3 (out of range) -> in_ready=3'b000 and out_valid=0 on the next edge.
